magic_nor_sequencer: RTL

Cycle-accurate executor for NOR/NOT-mapped netlists on a single memristor crossbar row under MAGIC semantics. It sits directly downstream of the NOR_NOT technology mapper. The mapper's gate list (for example the mapped half adder) is loaded as a program. Input bits are written into row cells, and the sequencer replays each gate as an INIT (output cell set to 1) plus EVAL (conditional 1→0 switch) pair. Result cells are then read back.

---
 rtl/magic_nor_sequencer_pkg.sv | 45 ++++
 rtl/magic_nor_sequencer_if.sv | 34 +++
 rtl/magic_cell_row.sv | 47 ++++
 rtl/magic_nor_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/magic_nor_sequencer_pkg.sv
// Shared types and sizing for the MAGIC NOR/NOT crossbar-row sequencer.
// Holds the gate encoding, FSM states and the illegal-gate rule.
package magic_pkg;

  localparam int CELLS      = 16;
  localparam int PROG_DEPTH = 32;
  localparam int AW         = $clog2(CELLS);
  localparam int PW         = $clog2(PROG_DEPTH);

  typedef enum logic [1:0] {
    OP_NOT  = 2'b00,
    OP_NOR  = 2'b01,
    OP_HALT = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_EVAL,
    ST_DONE
  } state_e;

  typedef struct packed {
    op_e           op;
    logic [AW-1:0] src_a;
    logic [AW-1:0] src_b;
    logic [AW-1:0] dst;
  } gate_t;

  // Both upper encodings (10 and 11) mean HALT.
  function automatic op_e decode_op(logic [1:0] raw);
    return raw[1] ? OP_HALT : op_e'(raw);
  endfunction

  // A gate may not overwrite one of its own inputs, and every used address must exist.
  function automatic logic gate_illegal(gate_t g);
    logic bad_addr;
    logic aliased;
    bad_addr = (int'(g.src_a) >= CELLS) || (int'(g.dst) >= CELLS) ||
               ((g.op == OP_NOR) && (int'(g.src_b) >= CELLS));
    aliased  = (g.dst == g.src_a) || ((g.op == OP_NOR) && (g.dst == g.src_b));
    return bad_addr || aliased;
  endfunction

endpackage

// File: rtl/magic_nor_sequencer_if.sv
// Host-side bus of the sequencer: program load, cell access, run control and status.
interface magic_nor_sequencer_if;
  import magic_pkg::*;

  logic          prog_we;
  logic [PW-1:0] prog_addr;
  logic [1:0]    prog_op;
  logic [AW-1:0] prog_src_a;
  logic [AW-1:0] prog_src_b;
  logic [AW-1:0] prog_dst;
  logic          cell_we;
  logic [AW-1:0] cell_addr;
  logic          cell_wdata;
  logic          cell_rdata;
  logic          start;
  logic [PW:0]   prog_len;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW:0]   gate_cnt;

  modport master (
    output prog_we, prog_addr, prog_op, prog_src_a, prog_src_b, prog_dst,
           cell_we, cell_addr, cell_wdata, start, prog_len,
    input  cell_rdata, busy, done, err, gate_cnt
  );

  modport slave (
    input  prog_we, prog_addr, prog_op, prog_src_a, prog_src_b, prog_dst,
           cell_we, cell_addr, cell_wdata, start, prog_len,
    output cell_rdata, busy, done, err, gate_cnt
  );

endinterface

// File: rtl/magic_cell_row.sv
// One memristor crossbar row: CELLS bits, a gate write port and a host write port
// selected by host_sel, three combinational gate taps and a registered readback.
module magic_cell_row
  import magic_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_sel,
  input  logic          gate_we,
  input  logic [AW-1:0] gate_addr,
  input  logic          gate_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic          host_data,
  input  logic [AW-1:0] tap_a_addr,
  input  logic [AW-1:0] tap_b_addr,
  input  logic [AW-1:0] tap_dst_addr,
  output logic          tap_a,
  output logic          tap_b,
  output logic          tap_dst,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);

  logic [CELLS-1:0] cells_q;

  assign tap_a   = cells_q[tap_a_addr];
  assign tap_b   = cells_q[tap_b_addr];
  assign tap_dst = cells_q[tap_dst_addr];

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let the read register see the new cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_q <= '0;
      rd_data <= 1'b0;
    end else begin
      if (host_sel) begin
        if (host_we) cells_q[host_addr] <= host_data;
      end else if (gate_we) begin
        cells_q[gate_addr] <= gate_data;
      end
      rd_data <= cells_q[rd_addr];
    end
  end

endmodule

// File: rtl/magic_nor_sequencer.sv
// Replays a NOR/NOT gate list on one crossbar row as INIT/EVAL pairs (MAGIC).
// Owns the FSM, program RAM and run counters; the row itself is magic_cell_row.
module magic_nor_sequencer
  import magic_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  magic_nor_sequencer_if.slave bus
);

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_inc;
  logic [PW:0]   len_q;
  logic [PW:0]   gate_cnt_q;
  logic          err_q;
  gate_t         prog_mem [PROG_DEPTH];
  gate_t         cur_gate;
  logic          cur_illegal;
  logic          next_halt;
  logic          first_halt;
  logic          last_gate;
  logic          is_idle;
  logic          start_ok;
  logic          stray_req;
  logic          tap_a, tap_b, tap_dst;
  logic          gate_we;
  logic          gate_data;

  assign pc_inc      = pc_q + PW'(1);
  assign cur_gate    = prog_mem[pc_q];
  assign cur_illegal = gate_illegal(cur_gate);
  assign next_halt   = (prog_mem[pc_inc].op == OP_HALT);
  assign last_gate   = ((PW+1)'(pc_q) + (PW+1)'(1)) == len_q;
  assign is_idle     = (state_q == ST_IDLE);
  assign start_ok    = is_idle && bus.start;
  assign stray_req   = bus.prog_we || bus.cell_we || bus.start;

  // HALT costs no cycles: it is resolved on the transition that would enter its INIT.
  // A write to entry 0 in the start cycle is forwarded so it takes effect first.
  assign first_halt = (bus.prog_we && (bus.prog_addr == '0)) ? bus.prog_op[1]
                                                              : (prog_mem[0].op == OP_HALT);

  // NOTE: the program RAM has no reset branch on purpose; its contents are
  // undefined after reset and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (is_idle && bus.prog_we) begin
      prog_mem[bus.prog_addr] <= '{op:    decode_op(bus.prog_op),
                                   src_a: bus.prog_src_a,
                                   src_b: bus.prog_src_b,
                                   dst:   bus.prog_dst};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ((bus.prog_len == '0) || first_halt) ? ST_DONE : ST_INIT;
      ST_INIT: state_d = ST_EVAL;
      ST_EVAL: state_d = (last_gate || next_halt) ? ST_DONE : ST_INIT;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gate_we   = 1'b0;
    gate_data = 1'b0;
    case (state_q)
      ST_INIT: begin
        gate_we   = !cur_illegal;
        gate_data = 1'b1;
      end
      ST_EVAL: begin
        gate_we   = !cur_illegal;
        gate_data = tap_dst & ~(tap_a | ((cur_gate.op == OP_NOR) & tap_b));
      end
      default: ;
    endcase
  end

  assign bus.busy     = !is_idle;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.err      = err_q;
  assign bus.gate_cnt = gate_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      len_q      <= '0;
      gate_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        pc_q       <= '0;
        len_q      <= bus.prog_len;
        gate_cnt_q <= '0;
        err_q      <= 1'b0;
      end
      if (state_q == ST_EVAL) begin
        pc_q <= pc_inc;
        if (cur_illegal) err_q <= 1'b1;
        else             gate_cnt_q <= gate_cnt_q + (PW+1)'(1);
      end
      // Host requests during a run are dropped but flagged.
      if (!is_idle && stray_req) err_q <= 1'b1;
    end
  end

  magic_cell_row u_row (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_sel     (is_idle),
    .gate_we      (gate_we),
    .gate_addr    (cur_gate.dst),
    .gate_data    (gate_data),
    .host_we      (bus.cell_we),
    .host_addr    (bus.cell_addr),
    .host_data    (bus.cell_wdata),
    .tap_a_addr   (cur_gate.src_a),
    .tap_b_addr   (cur_gate.src_b),
    .tap_dst_addr (cur_gate.dst),
    .tap_a        (tap_a),
    .tap_b        (tap_b),
    .tap_dst      (tap_dst),
    .rd_addr      (bus.cell_addr),
    .rd_data      (bus.cell_rdata)
  );

endmodule
